// File: rtl/pcie_phy_pkg.sv
// Shared PHY constants and types: byte width, COM symbol, and the serializer state encoding.
package pcie_phy_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned BIT_CNT_W  = $clog2(BYTE_W);
    localparam int unsigned SYNC_CNT_W = 8;

    localparam logic [BYTE_W-1:0] COM_K28_5 = 8'hBC;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } phy_state_e;

endpackage

// File: rtl/par_to_serial_if.sv
// Byte-in / bit-out handshake bundle of the parallel-to-serial converter.
interface par_to_serial_if;
    import pcie_phy_pkg::*;

    logic [BYTE_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;
    logic              data_out;
    logic              active_out;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  data_out,
        input  active_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output data_out,
        output active_out
    );

endinterface

// File: rtl/ps_hold_reg.sv
// One-entry holding register between the byte handshake and the shifter, with its ready logic.
module ps_hold_reg
    import pcie_phy_pkg::*;
(
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              run,
    input  logic              boundary,
    input  logic              valid_in,
    input  logic [BYTE_W-1:0] data_in,
    output logic              ready_c,
    output logic              hold_full,
    output logic [BYTE_W-1:0] hold
);

    logic accept_c;

    // A full hold can still take a byte on the boundary, because the shifter drains it that edge.
    assign ready_c  = run & (~hold_full | boundary);
    assign accept_c = valid_in & ready_c;

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (accept_c) begin
            hold      <= data_in;
            hold_full <= 1'b1;
        end else if (boundary) begin
            hold_full <= 1'b0;
        end
    end

endmodule

// File: rtl/par_to_serial.sv
// Byte-to-bit serializer, MSB first, with post-reset COM sync burst and fill on idle.
// Define PAR_TO_SERIAL_IDLE_COM_EN to send IDLE_SYM as idle fill in RUN instead of 8'h00.
module par_to_serial
    import pcie_phy_pkg::*;
#(
    parameter logic [BYTE_W-1:0] IDLE_SYM   = COM_K28_5,
    parameter int unsigned       SYNC_BYTES = 4
) (
    input  logic           clk_32f,
    input  logic           reset,
    par_to_serial_if.slave bus
);

`ifdef PAR_TO_SERIAL_IDLE_COM_EN
    localparam logic [BYTE_W-1:0] RUN_FILL = IDLE_SYM;
`else
    localparam logic [BYTE_W-1:0] RUN_FILL = 8'h00;
`endif

    localparam logic [SYNC_CNT_W-1:0] SYNC_LAST = SYNC_CNT_W'(SYNC_BYTES - 1);
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(BYTE_W - 1);

    phy_state_e            state, state_nxt;
    logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [SYNC_CNT_W-1:0] sync_cnt, sync_cnt_nxt;
    logic [BYTE_W-1:0]     shreg, shreg_nxt;
    logic                  active, active_nxt;
    logic [BYTE_W-1:0]     fill;
    logic                  boundary;
    logic                  ready_c;
    logic                  hold_full;
    logic [BYTE_W-1:0]     hold;

    assign boundary = (bit_cnt == LAST_BIT);

    ps_hold_reg u_hold (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .run      (state == RUN),
        .boundary (boundary),
        .valid_in (bus.valid_in),
        .data_in  (bus.data_in),
        .ready_c  (ready_c),
        .hold_full(hold_full),
        .hold     (hold)
    );

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state    <= SYNC;
            bit_cnt  <= '0;
            sync_cnt <= '0;
            shreg    <= IDLE_SYM;
            active   <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            sync_cnt <= sync_cnt_nxt;
            shreg    <= shreg_nxt;
            active   <= active_nxt;
        end
    end

    // The reset-loaded symbol is sync byte 0; the byte loaded on the last sync boundary already belongs to RUN.
    always_comb begin
        state_nxt    = state;
        sync_cnt_nxt = sync_cnt;
        bit_cnt_nxt  = bit_cnt + BIT_CNT_W'(1);
        shreg_nxt    = {shreg[BYTE_W-2:0], 1'b0};
        active_nxt   = active;
        fill         = RUN_FILL;

        case (state)
            SYNC: begin
                fill = IDLE_SYM;
                if (boundary) begin
                    sync_cnt_nxt = sync_cnt + SYNC_CNT_W'(1);
                    if (sync_cnt == SYNC_LAST) begin
                        state_nxt = RUN;
                        fill      = RUN_FILL;
                    end
                end
            end
            RUN: begin
                fill = RUN_FILL;
            end
        endcase

        if (boundary) begin
            if (hold_full) begin
                shreg_nxt  = hold;
                active_nxt = 1'b1;
            end else begin
                shreg_nxt  = fill;
                active_nxt = 1'b0;
            end
        end
    end

    assign bus.data_out   = shreg[BYTE_W-1];
    assign bus.active_out = active;
    assign bus.ready_out  = ready_c;

endmodule

// File: tb/tb_par_to_serial.sv
// Self-checking bench for par_to_serial: byte-window queue model plus directed literal pins and random traffic.
module tb_par_to_serial;
    import pcie_phy_pkg::*;

    localparam int unsigned SB = 4;
`ifdef PAR_TO_SERIAL_IDLE_COM_EN
    localparam logic [7:0] RUN_FILL = 8'hBC;
`else
    localparam logic [7:0] RUN_FILL = 8'h00;
`endif

    logic clk_32f = 1'b0;
    logic reset   = 1'b0;

    par_to_serial_if bus ();

    par_to_serial #(.IDLE_SYM(8'hBC), .SYNC_BYTES(SB)) dut (
        .clk_32f(clk_32f),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_32f = ~clk_32f;

    // Model: which byte window we are in, bit position inside it, the byte on the wire, accepted-but-unsent bytes.
    int         win;
    int         ph;
    logic [7:0] cur;
    logic       cur_act;
    logic [7:0] q[$];

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] hist   = '0;
    int          act_cnt = 0;
    int          rdy_cnt = 0;
    int          obs     = 0;

    function automatic void model_init();
        win     = 0;
        ph      = 0;
        cur     = 8'hBC;
        cur_act = 1'b0;
        q.delete();
    endfunction

    function automatic logic exp_ready();
        return !reset && (win >= int'(SB)) && (q.size() == 0 || ph == 7);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("data_out",   32'(bus.data_out),   32'(cur[3'(7 - ph)]));
        chk("active_out", 32'(bus.active_out), 32'(cur_act));
        chk("ready_out",  32'(bus.ready_out),  32'(exp_ready()));
        hist = {hist[30:0], bus.data_out};
        if (bus.active_out) act_cnt++;
        if (bus.ready_out)  rdy_cnt++;
    endtask

    // One clock: drive inputs, advance the model on the edge, compare on the following falling edge.
    task automatic cycle(input logic v, input logic [7:0] d, output logic acc);
        bus.valid_in = v;
        bus.data_in  = d;
        acc = v & exp_ready();
        @(posedge clk_32f);
        if (!reset) begin
            if (ph == 7) begin
                win++;
                if (q.size() > 0) begin
                    cur     = q.pop_front();
                    cur_act = 1'b1;
                end else begin
                    cur     = (win < int'(SB)) ? 8'hBC : RUN_FILL;
                    cur_act = 1'b0;
                end
            end
            if (acc) q.push_back(d);
            ph = (ph + 1) % 8;
            obs++;
        end
        @(negedge clk_32f);
        check_outputs();
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) cycle(1'b0, 8'h00, acc);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        model_init();
        #1 check_outputs();
        repeat (n) begin
            @(posedge clk_32f);
            @(negedge clk_32f);
            check_outputs();
        end
        reset = 1'b0;
        obs   = 0;
        #1 check_outputs();
    endtask

    initial begin
        logic       acc;
        int         idx;
        int         guard;
        int         acc_at;
        logic [7:0] stream [3];

        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
        model_init();
        #2;

        // Sync burst after reset with no traffic.
        do_reset(3);
        chk("reset_data_out", 32'(bus.data_out), 32'd1);
        rdy_cnt = 0;
        hist    = {hist[30:0], bus.data_out};
        idle(31);
        chk("sync_bits", hist, 32'hBCBC_BCBC);
        chk("sync_ready_low", 32'(rdy_cnt), 32'd0);
        idle(1);
        chk("ready_at_32", 32'(bus.ready_out), 32'd1);

        // Single byte sent one cycle after a boundary.
        guard = 0;
        while (ph != 0 && guard < 16) begin idle(1); guard++; end
        cycle(1'b1, 8'hA5, acc);
        chk("a5_accepted", 32'(acc), 32'd1);
        act_cnt = 0;
        idle(14);
        chk("a5_bits", 32'(hist[7:0]), 32'h0000_00A5);
        idle(8);
        chk("fill_bits", 32'(hist[7:0]), 32'(RUN_FILL));
        chk("a5_active_len", 32'(act_cnt), 32'd8);

        // Back-to-back stream with valid held high.
        stream[0] = 8'h01; stream[1] = 8'h02; stream[2] = 8'h03;
        act_cnt = 0;
        idx = 0;
        guard = 0;
        while (idx < 3 && guard < 100) begin
            cycle(1'b1, stream[idx], acc);
            if (acc) idx++;
            guard++;
        end
        chk("stream_accept_timeout", 32'(idx), 32'd3);
        guard = 0;
        while ((q.size() > 0 || ph != 7 || cur != 8'h03 || !cur_act) && guard < 40) begin
            idle(1);
            guard++;
        end
        chk("stream_drain_timeout", 32'(guard < 40), 32'd1);
        chk("stream_bits", {8'h00, hist[23:0]}, 32'h0001_0203);
        chk("stream_active_len", 32'(act_cnt), 32'd24);

        // Valid held through the sync phase: accepted exactly once at the first ready edge.
        do_reset(2);
        hist   = {hist[30:0], bus.data_out};
        acc_at = -1;
        guard  = 0;
        while (acc_at < 0 && guard < 60) begin
            idx = obs;
            cycle(1'b1, 8'hFF, acc);
            if (acc) acc_at = idx;
            guard++;
        end
        chk("ff_accept_cycle", 32'(acc_at), 32'd32);
        while (obs < 47) idle(1);
        chk("ff_bits", 32'(hist[7:0]), 32'h0000_00FF);
        idle(8);
        chk("ff_once", 32'(hist[7:0]), 32'(RUN_FILL));

        // Reset mid-byte with a second byte held: neither may appear afterwards.
        cycle(1'b1, 8'h5A, acc);
        guard = 0;
        while (!acc && guard < 10) begin cycle(1'b1, 8'h5A, acc); guard++; end
        cycle(1'b1, 8'hC3, acc);
        guard = 0;
        while (!acc && guard < 10) begin cycle(1'b1, 8'hC3, acc); guard++; end
        bus.valid_in = 1'b0;
        guard = 0;
        while (!(cur == 8'h5A && cur_act && ph == 3) && guard < 20) begin idle(1); guard++; end
        chk("mid_byte_reached", 32'(guard < 20), 32'd1);
        chk("c3_held", 32'(q.size()), 32'd1);
        do_reset(2);
        act_cnt = 0;
        hist    = {hist[30:0], bus.data_out};
        idle(31);
        chk("resync_bits", hist, 32'hBCBC_BCBC);
        idle(24);
        chk("no_stale_bytes", 32'(act_cnt), 32'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                cycle(1'($urandom_range(0, 1)), 8'($urandom), acc);
            end
        end
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/par_to_serial.md
PAR_TO_SERIAL -- requirements
Module: par_to_serial

Interface
REQ-001 Parameter IDLE_SYM, default 8'hBC (COM, K28.5), sets the symbol shifted during sync and idle.
REQ-002 Parameter SYNC_BYTES, default 4, sets the number of IDLE_SYM bytes sent after reset before data is accepted; legal range 1..255.
REQ-003 Port clk_32f, input, 1 bit: the single clock, serial bit rate; every flop runs on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port data_in, input, 8 bits: parallel byte from the upstream lane logic.
REQ-006 Port valid_in, input, 1 bit: data_in is valid.
REQ-007 Port ready_out, output, 1 bit: the block accepts a byte this cycle.
REQ-008 Port data_out, output, 1 bit: serial bit, MSB first, equal to shreg[7].
REQ-009 Port active_out, output, 1 bit: the byte now being shifted is user data, not fill.

Function
REQ-010 A byte transfers on a rising edge with valid_in=1 and ready_out=1; otherwise valid_in is ignored and the source holds data_in.
REQ-011 The internal datapath is an 8-bit shift register shreg, a 3-bit bit_cnt, a 1-entry holding register hold with a flag hold_full, and a sync_cnt.
REQ-012 The state machine has two states: SYNC and RUN; reset enters SYNC.
REQ-013 Each cycle bit_cnt increments modulo 8 and shreg shifts left by one bit; the cycle with bit_cnt==7 is the boundary.
REQ-014 At each boundary shreg loads hold and active becomes 1 if hold_full=1 (and hold_full clears), else shreg loads the fill symbol and active becomes 0.
REQ-015 In SYNC the fill symbol is IDLE_SYM, hold is never loaded, and ready_out=0.
REQ-016 In SYNC, sync_cnt increments at each boundary; at the boundary where sync_cnt reaches SYNC_BYTES-1, the state becomes RUN.
REQ-017 In RUN, ready_out = ~hold_full | (bit_cnt==7).
REQ-018 An accept and a drain in the same boundary cycle drains the old hold into shreg and writes the new byte to hold, leaving hold_full=1.
REQ-019 There is no bypass: an accepted byte first appears on data_out at the boundary following its acceptance edge; minimum latency is 1 cycle, maximum 8.
REQ-020 Back-to-back valid bytes stream without gaps at 1 byte per 8 clocks.
REQ-021 active_out equals the active flag and changes only on the edge following a boundary.

Reset
REQ-022 While reset=1: state=SYNC, bit_cnt=0, sync_cnt=0, hold_full=0, shreg=IDLE_SYM, and the active flag=0.
REQ-023 While reset=1 the outputs are ready_out=0, active_out=0, and data_out=IDLE_SYM[7] (1 for the default).
REQ-024 Reset asserted mid-byte discards the partial byte and any held byte without completing them.
REQ-025 After reset deasserts, transmission restarts with SYNC_BYTES full IDLE_SYM bytes.

Configuration
REQ-026 Macro PAR_TO_SERIAL_IDLE_COM_EN selects the fill used in RUN.
REQ-027 With PAR_TO_SERIAL_IDLE_COM_EN defined, the RUN fill symbol is IDLE_SYM.
REQ-028 Without PAR_TO_SERIAL_IDLE_COM_EN, the RUN fill symbol is 8'h00; the SYNC phase is unchanged.

Structure
REQ-029 Shared package pcie_phy_pkg holds the COM_K28_5 = 8'hBC constant, the SYNC/RUN state typedef, and the byte-width constant 8.
REQ-030 The holding register with its flag and ready logic is one sub-module, ps_hold_reg; all other logic stays in par_to_serial.

Verification
REQ-031 Reset, then release, with valid_in=0 -> 32 bits of 10111100 repeated, ready_out=0 for the first 32 cycles, then ready_out=1.
REQ-032 In RUN, idle, send 8'hA5 one cycle after a boundary -> 10100101 starts at the next boundary, active_out=1 for exactly those 8 bits.
REQ-033 Stream 8'h01, 8'h02, 8'h03 with valid_in held high -> 24 contiguous data bits, no fill, ready_out high only at boundaries once hold is full.
REQ-034 Hold valid_in=1 with 8'hFF while ready_out=0 -> the byte is accepted exactly once, on the first ready_out=1 edge.
REQ-035 Assert reset at bit_cnt=3 of byte 8'h5A with 8'hC3 held -> neither byte is emitted, and the SYNC sequence restarts.
REQ-036 Build without PAR_TO_SERIAL_IDLE_COM_EN, then go idle in RUN -> fill is 00000000, while the SYNC phase still sends 8'hBC.
